action_selector: RTL and testbench
==================================

ACTION_SELECTOR -- requirements
Module: action_selector

Interface
REQ-001 SHALL use one clock and one reset: clock `clk`, reset `rst_n`, asynchronous and active-low.
REQ-002 Port `clk`  input  1  rising-edge clock for all state.
REQ-003 Port `rst_n`  input  1  asynchronous active-low reset.
REQ-004 Port `start`  input  1  active-low enable: 0 = select an action every cycle; 1 = hold outputs and LFSR.
REQ-005 Port `q_values`  input  64  four signed Q8.8 Q-values; Q_i = q_values[16i+15:16i], i = 0..3.
REQ-006 Port `epsilon`  input  16  unsigned Q8.8 exploration threshold; 0x0100 = 1.0.
REQ-007 Port `action`  output  4  one-hot selected action, bit i = action i; 0000 = none yet.
REQ-008 Port `explored`  output  1  1 when the current `action` came from the random branch.

Function
REQ-009 Policy: epsilon-greedy with an internal 16-bit Fibonacci LFSR, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1), shifting left and feeding back into bit 0.
REQ-010 Random fraction r = {8'h00, lfsr[7:0]}, Q8.8 in [0, 255/256].
REQ-011 Explore when r < epsilon (unsigned 16-bit compare), else exploit.
REQ-012 epsilon >= 0x0100: always explore; epsilon = 0: always exploit.
REQ-013 Explore: action = one-hot of index lfsr[9:8].
REQ-014 Exploit: action = one-hot of argmax of Q_0..Q_3 under signed 16-bit compare.
REQ-015 Ties: lowest index wins.
REQ-016 Argmax is combinational, as a two-level compare tree: (Q0,Q1), (Q2,Q3), then the two winners.
REQ-017 Latency: on each rising `clk` with start=0, `action`/`explored` register the decision made from the current inputs and current LFSR value; LFSR advances on the same edge.
REQ-018 With start=1: `action`, `explored` and the LFSR hold their values.
REQ-019 Inputs may change every cycle; no handshake.
REQ-020 The registered `action` SHALL always be one-hot or 0000.

Reset
REQ-021 rst_n=0 asynchronously sets action=0000, explored=0, lfsr=16'hACE1.
REQ-022 Reset asserted mid-operation overrides start and discards the pending decision.
REQ-023 After rst_n deasserts, the first action appears on the first rising edge with start=0.

Structure
REQ-024 Shared package holds: NUM_ACTIONS=4, Q_WIDTH=16, Q_FRAC=8, LFSR_SEED=16'hACE1, and the LFSR tap mask.
REQ-025 Argmax is one sub-module, `q_argmax` (4 signed inputs -> 2-bit index).
REQ-026 LFSR, compare and output registers are inline in `action_selector`.

Verification
REQ-027 Reset: rst_n=0 with start=0 -> action=0000, explored=0 immediately, without a clock edge.
REQ-028 Exploit: epsilon=0, q_values=0x000C_0001_0002_0003, start=0, one edge -> action=1000, explored=0; then Q0=0x0007, one edge -> action=1000.
REQ-029 Ties and signed compare: epsilon=0, Q=(0x0005,0x0005,0xFF00,0x8000) for Q0..Q3 -> action=0001; Q=(0xFFFF,0x8000,0xFFFE,0xFFFF) -> action=0001.
REQ-030 Explore: epsilon=0x0100, start=0 from seed -> every cycle explored=1 and action = one-hot(lfsr[9:8]), checked against a reference LFSR model over 100 cycles.
REQ-031 Hold: start=1 for 5 cycles -> action and LFSR unchanged; start=0 resumes the sequence with no skipped states.
REQ-032 Statistics: epsilon=0x00E0 (0.875) over 2560 cycles -> explored rate 224/256 ±2%, action always one-hot.

Source files
------------

// File: rtl/action_selector_pkg.sv
// Shared definitions for the epsilon-greedy action selector.
//   NUM_ACTIONS / Q_WIDTH / Q_FRAC describe the Q-value vector (signed Q8.8).
//   LFSR_SEED is the reset value of the exploration LFSR.
//   LFSR_TAPS marks bits 15,13,12,10 (x^16+x^14+x^13+x^11+1).
//   The package also provides one-hot encoding and a single LFSR step.
package action_selector_pkg;

  localparam int NUM_ACTIONS = 4;
  localparam int Q_WIDTH     = 16;
  localparam int Q_FRAC      = 8;
  localparam int IDX_WIDTH   = $clog2(NUM_ACTIONS);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [NUM_ACTIONS-1:0] one_hot(input logic [IDX_WIDTH-1:0] idx);
    logic [NUM_ACTIONS-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Fibonacci form: XOR of the tapped bits shifts in at bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/action_selector_q_argmax.sv
// q_argmax: combinational argmax over four signed Q8.8 values.
//   q0..q3 : signed Q-values
//   index  : index of the largest value; ties resolve to the lowest index
// Built as a two-level tree: (q0,q1) and (q2,q3), then the two winners.
module q_argmax
  import action_selector_pkg::*;
(
  input  logic signed [Q_WIDTH-1:0]   q0,
  input  logic signed [Q_WIDTH-1:0]   q1,
  input  logic signed [Q_WIDTH-1:0]   q2,
  input  logic signed [Q_WIDTH-1:0]   q3,
  output logic        [IDX_WIDTH-1:0] index
);

  logic                      pick_1;
  logic                      pick_3;
  logic                      pick_hi;
  logic signed [Q_WIDTH-1:0] best_lo;
  logic signed [Q_WIDTH-1:0] best_hi;

  // Strict greater-than so an equal later entry never displaces an earlier one.
  assign pick_1  = (q1 > q0);
  assign pick_3  = (q3 > q2);
  assign best_lo = pick_1 ? q1 : q0;
  assign best_hi = pick_3 ? q3 : q2;
  assign pick_hi = (best_hi > best_lo);

  assign index = pick_hi ? {1'b1, pick_3} : {1'b0, pick_1};

endmodule

// File: rtl/action_selector.sv
// action_selector: epsilon-greedy action selection over four Q-values.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : active-low enable (0 = decide every cycle, 1 = hold)
//   q_values : four signed Q8.8 values, Q_i = q_values[16i+15:16i]
//   epsilon  : unsigned Q8.8 exploration threshold (0x0100 = 1.0)
//   action   : registered one-hot action, 0000 until the first decision
//   explored : 1 when the registered action came from the random branch
module action_selector
  import action_selector_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_ACTIONS*Q_WIDTH-1:0] q_values,
  input  logic [15:0]                    epsilon,
  output logic [NUM_ACTIONS-1:0]         action,
  output logic                           explored
);

  logic signed [Q_WIDTH-1:0] q_lane [NUM_ACTIONS];
  logic [15:0]               lfsr_reg;
  logic [15:0]               rand_frac;
  logic [IDX_WIDTH-1:0]      greedy_idx;
  logic                      explore_next;
  logic [NUM_ACTIONS-1:0]    action_next;

  generate
    for (genvar gi = 0; gi < NUM_ACTIONS; gi++) begin : g_lane
      assign q_lane[gi] = q_values[gi*Q_WIDTH +: Q_WIDTH];
    end
  endgenerate

  q_argmax u_argmax (
    .q0    (q_lane[0]),
    .q1    (q_lane[1]),
    .q2    (q_lane[2]),
    .q3    (q_lane[3]),
    .index (greedy_idx)
  );

  // Random fraction lives in [0, 255/256], so epsilon >= 1.0 always explores
  // and epsilon = 0 never does, with no special casing.
  assign rand_frac    = {8'h00, lfsr_reg[7:0]};
  assign explore_next = (rand_frac < epsilon);
  assign action_next  = explore_next ? one_hot(lfsr_reg[9:8]) : one_hot(greedy_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_SEED;
      action   <= '0;
      explored <= 1'b0;
    end else if (!start) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
      action   <= action_next;
      explored <= explore_next;
    end
  end

endmodule

// File: tb/tb_action_selector.sv
// Self-checking bench for action_selector: directed vectors plus randomized
// traffic compared cycle by cycle against a behavioural reference model.
module tb_action_selector;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] q_values;
  logic [15:0] epsilon;
  logic [3:0]  action;
  logic        explored;

  int checks = 0;
  int errors = 0;

  // reference model state
  int unsigned ref_lfsr;
  logic [3:0]  exp_action;
  logic        exp_explored;

  action_selector dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .q_values (q_values),
    .epsilon  (epsilon),
    .action   (action),
    .explored (explored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1: term x^k corresponds to bit k-1.
  function automatic int unsigned model_next(input int unsigned s);
    int unsigned fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return ((s << 1) & 32'hFFFF) | fb;
  endfunction

  function automatic int model_argmax(input logic [63:0] qv);
    int best_i;
    int best_v;
    int v;
    best_i = 0;
    best_v = int'($signed(qv[15:0]));
    for (int i = 1; i < 4; i++) begin
      v = int'($signed(qv[16*i +: 16]));
      if (v > best_v) begin
        best_v = v;
        best_i = i;
      end
    end
    return best_i;
  endfunction

  // One clock: predict from the inputs present before the edge, then compare.
  task automatic cycle(input string tag);
    int frac;
    int idx;
    if (!start) begin
      frac = int'(ref_lfsr % 256);
      if (frac < int'(epsilon)) begin
        idx = int'((ref_lfsr / 256) % 4);
        exp_explored = 1'b1;
      end else begin
        idx = model_argmax(q_values);
        exp_explored = 1'b0;
      end
      exp_action = 4'(1 << idx);
      ref_lfsr = model_next(ref_lfsr);
    end
    @(posedge clk);
    #1;
    check({tag, "_action"}, {12'h0, action}, {12'h0, exp_action});
    check({tag, "_explored"}, {15'h0, explored}, {15'h0, exp_explored});
  endtask

  task automatic model_reset();
    ref_lfsr = 32'hACE1;
    exp_action = 4'b0000;
    exp_explored = 1'b0;
  endtask

  function automatic logic [63:0] rand_q();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int explored_cnt;
    int model_cnt;
    int r;
    logic [3:0] held_action;
    logic       held_explored;

    // Reset is visible without any clock edge.
    rst_n = 1'b0;
    start = 1'b0;
    q_values = '0;
    epsilon = '0;
    model_reset();
    #3;
    check("reset_action", {12'h0, action}, 16'h0000);
    check("reset_explored", {15'h0, explored}, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_hold_action", {12'h0, action}, 16'h0000);
    rst_n = 1'b1;

    // Exploit: Q3 = 0x000C is the maximum.
    epsilon  = 16'h0000;
    q_values = 64'h000C_0001_0002_0003;
    cycle("exploit1");
    check("exploit1_const", {12'h0, action}, 16'h0008);
    q_values[15:0] = 16'h0007;
    cycle("exploit2");
    check("exploit2_const", {12'h0, action}, 16'h0008);

    // Ties and signed comparison.
    q_values = {16'h8000, 16'hFF00, 16'h0005, 16'h0005};
    cycle("tie1");
    check("tie1_const", {12'h0, action}, 16'h0001);
    q_values = {16'hFFFF, 16'hFFFE, 16'h8000, 16'hFFFF};
    cycle("tie2");
    check("tie2_const", {12'h0, action}, 16'h0001);

    // Reset mid-operation with start=0 discards state and reseeds.
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_action", {12'h0, action}, 16'h0000);
    check("midreset_explored", {15'h0, explored}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Always explore from the seed for 100 cycles.
    epsilon = 16'h0100;
    for (int i = 0; i < 100; i++) begin
      q_values = rand_q();
      cycle("explore");
    end

    // Hold for 5 cycles, then resume with no skipped LFSR states.
    held_action = action;
    held_explored = explored;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      q_values = rand_q();
      cycle("hold");
      check("hold_const_action", {12'h0, action}, {12'h0, held_action});
      check("hold_const_explored", {15'h0, explored}, {15'h0, held_explored});
    end
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      q_values = rand_q();
      cycle("resume");
    end

    // Mixed random traffic: random thresholds, Q-values and enable.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      epsilon = 16'h0000;
      else if (r == 1) epsilon = 16'($urandom_range(256, 65535));
      else             epsilon = 16'($urandom_range(0, 255));
      start = ($urandom_range(0, 3) == 0);
      q_values = rand_q();
      cycle("random");
    end
    start = 1'b0;

    // Exploration statistics at epsilon = 0.875.
    epsilon = 16'h00E0;
    explored_cnt = 0;
    model_cnt = 0;
    for (int i = 0; i < 2560; i++) begin
      q_values = rand_q();
      cycle("stats");
      if (explored) explored_cnt++;
      if (exp_explored) model_cnt++;
      checks++;
      assert ($countones(action) == 1)
        else begin
          errors++;
          $error("FAIL stats_onehot observed=%0h expected=one-hot", action);
        end
    end
    check("stats_count", 16'(explored_cnt), 16'(model_cnt));
    checks++;
    assert (explored_cnt * 100 >= 2560 * 855 / 10 && explored_cnt * 100 <= 2560 * 895 / 10)
      else begin
        errors++;
        $error("FAIL stats_rate observed=%0d expected=2189..2291 of 2560", explored_cnt);
      end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
